// File: rtl/i2c_regfile_arbiter.sv
// i2c_regfile_arbiter: 2^ADDR_W x DATA_W flop register file shared between
// the I2C slave (one-cycle rd/wr strobes) and a host req/ack port.
// Ports:
//   clk, reset             : system clock, synchronous active-high reset
//   i2c_addr/wdata/wr/rd   : I2C strobed request, latched into a 1-deep slot
//   i2c_rdata/rvalid       : I2C read data and one-cycle completion pulse
//   i2c_ovf                : sticky, strobe dropped because the slot was full
//   i2c_wp_err             : pulse, protected I2C write was blocked
//   host_req/we/addr/wdata : host request, held until host_ack
//   host_ack/rdata         : host completion pulse and read data
// Optional feature: define I2C_REGFILE_WP_EN to block I2C writes to
// addresses 0..WP_TOP (host writes are never blocked).
module i2c_regfile_arbiter #(
    parameter int ADDR_W = 5,
    parameter int DATA_W = 8,
    parameter int WP_TOP = 3
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [ADDR_W-1:0] i2c_addr,
    input  logic [DATA_W-1:0] i2c_wdata,
    input  logic              i2c_wr,
    input  logic              i2c_rd,
    output logic [DATA_W-1:0] i2c_rdata,
    output logic              i2c_rvalid,
    output logic              i2c_ovf,
    output logic              i2c_wp_err,
    input  logic              host_req,
    input  logic              host_we,
    input  logic [ADDR_W-1:0] host_addr,
    input  logic [DATA_W-1:0] host_wdata,
    output logic              host_ack,
    output logic [DATA_W-1:0] host_rdata
);

    localparam int DEPTH = 1 << ADDR_W;

`ifdef I2C_REGFILE_WP_EN
    localparam bit WP_ON = 1'b1;
`else
    localparam bit WP_ON = 1'b0;
`endif

    typedef enum logic [1:0] {
        S_IDLE,
        S_ACC_I2C,
        S_ACC_HOST
    } state_t;

    state_t r_state;
    state_t w_next;

    logic              r_last_i2c;
    logic              r_slot_v;
    logic              r_slot_we;
    logic [ADDR_W-1:0] r_slot_addr;
    logic [DATA_W-1:0] r_slot_data;
    logic              r_acc_we;
    logic [ADDR_W-1:0] r_acc_addr;
    logic [DATA_W-1:0] r_acc_data;
    logic [DATA_W-1:0] r_mem [DEPTH];
    logic [DATA_W-1:0] r_i2c_rdata;
    logic              r_i2c_rvalid;
    logic              r_i2c_ovf;
    logic              r_wp_err;
    logic              r_host_ack;
    logic [DATA_W-1:0] r_host_rdata;

    logic w_i2c_stb;
    logic w_host_cand;
    logic w_gnt_i2c;
    logic w_gnt_host;
    logic w_prot;
    logic w_mem_we;
    logic w_i2c_rd_done;
    logic w_host_done;
    logic w_wp_block;

    assign w_i2c_stb = i2c_wr | i2c_rd;
    // The ack cycle must not re-grant the host on a late-dropped req.
    assign w_host_cand = host_req & ~r_host_ack;
    // On a tie the side not granted last wins.
    assign w_gnt_i2c = (r_state == S_IDLE) & r_slot_v
                     & (~w_host_cand | ~r_last_i2c);
    assign w_gnt_host = (r_state == S_IDLE) & w_host_cand & ~w_gnt_i2c;
    assign w_prot = WP_ON && (int'(r_acc_addr) <= WP_TOP);

    // State register
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Next state
    always_comb begin
        w_next = S_IDLE;
        unique case (r_state)
            S_IDLE: begin
                if (w_gnt_i2c) begin
                    w_next = S_ACC_I2C;
                end else if (w_gnt_host) begin
                    w_next = S_ACC_HOST;
                end
            end
            S_ACC_I2C:  w_next = S_IDLE;
            S_ACC_HOST: w_next = S_IDLE;
            default:    w_next = S_IDLE;
        endcase
    end

    // Access-cycle actions
    always_comb begin
        w_mem_we      = 1'b0;
        w_i2c_rd_done = 1'b0;
        w_host_done   = 1'b0;
        w_wp_block    = 1'b0;
        unique case (r_state)
            S_ACC_I2C: begin
                if (r_acc_we) begin
                    w_wp_block = w_prot;
                    w_mem_we   = ~w_prot;
                end else begin
                    w_i2c_rd_done = 1'b1;
                end
            end
            S_ACC_HOST: begin
                w_host_done = 1'b1;
                w_mem_we    = r_acc_we;
            end
            default: ;
        endcase
    end

    // Datapath, pending slot and storage
    always_ff @(posedge clk) begin
        if (reset) begin
            r_last_i2c   <= 1'b0;
            r_slot_v     <= 1'b0;
            r_slot_we    <= 1'b0;
            r_slot_addr  <= '0;
            r_slot_data  <= '0;
            r_acc_we     <= 1'b0;
            r_acc_addr   <= '0;
            r_acc_data   <= '0;
            r_i2c_rdata  <= '0;
            r_i2c_rvalid <= 1'b0;
            r_i2c_ovf    <= 1'b0;
            r_wp_err     <= 1'b0;
            r_host_ack   <= 1'b0;
            r_host_rdata <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                r_mem[i] <= '0;
            end
        end else begin
            r_i2c_rvalid <= w_i2c_rd_done;
            r_host_ack   <= w_host_done;
            r_wp_err     <= w_wp_block;
            if (w_i2c_rd_done) begin
                r_i2c_rdata <= r_mem[r_acc_addr];
            end
            if (w_host_done && !r_acc_we) begin
                r_host_rdata <= r_mem[r_acc_addr];
            end
            if (w_mem_we) begin
                r_mem[r_acc_addr] <= r_acc_data;
            end
            // A strobe in the grant cycle refills the slot being freed.
            if (w_i2c_stb) begin
                if (!r_slot_v || w_gnt_i2c) begin
                    r_slot_v    <= 1'b1;
                    r_slot_we   <= i2c_wr;
                    r_slot_addr <= i2c_addr;
                    r_slot_data <= i2c_wdata;
                end else begin
                    r_i2c_ovf <= 1'b1;
                end
            end else if (w_gnt_i2c) begin
                r_slot_v <= 1'b0;
            end
            if (w_gnt_i2c) begin
                r_acc_we   <= r_slot_we;
                r_acc_addr <= r_slot_addr;
                r_acc_data <= r_slot_data;
                r_last_i2c <= 1'b1;
            end else if (w_gnt_host) begin
                r_acc_we   <= host_we;
                r_acc_addr <= host_addr;
                r_acc_data <= host_wdata;
                r_last_i2c <= 1'b0;
            end
        end
    end

    assign i2c_rdata  = r_i2c_rdata;
    assign i2c_rvalid = r_i2c_rvalid;
    assign i2c_ovf    = r_i2c_ovf;
    assign i2c_wp_err = r_wp_err;
    assign host_ack   = r_host_ack;
    assign host_rdata = r_host_rdata;

endmodule
